psum_accumulator: RTL and testbench
===================================

# psum_accumulator

Accumulates the registered 16-bit signed products of the multi-precision multiply unit into dot-product results, one result per group of beats terminated by `in_last`. It sits directly downstream of the multiply unit and holds one finished result in an output register behind a valid/ready handshake. Upstream control is responsible for aligning `in_valid` with the multiplier's one-cycle product latency.

## Interface
- `ACC_W`, 32: accumulator and result width; must be 17 or more.
- `CNT_W`, 16: beat-counter width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_psum` beat valid.
- `in_ready`  out  1  beat accepted when both `in_valid` and `in_ready` are high.
- `in_psum`  in  16  signed product from the multiply unit.
- `in_mode`  in  2  precision of the beat: 00 NOOP, 01 8x8, 10 4x4, 11 2x2.
- `in_last`  in  1  beat closes the current group.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  ACC_W  signed group sum.
- `out_count`  out  CNT_W  number of beats accumulated in the group.
- `out_mode`  out  2  mode latched at the group's first beat.
- `out_ovf`  out  1  group overflowed ACC_W (sticky within the group).
- `out_mode_err`  out  1  a beat's mode differed from the latched mode (sticky within the group).

## Operation
- FSM has two states.
  - IDLE: no open group.
  - ACCUM: group open.
- `in_ready = !(out_valid && !out_ready)`. A stalled output register blocks the input; there is no skid buffer.
- Accepted NOOP beat: fully ignored, including `in_last`. No state change.
- Accepted non-NOOP beat in IDLE:
  - acc = sext(`in_psum`), count = 1.
  - Latch `in_mode`; ovf = 0, mode_err = 0.
  - Go to ACCUM.
- Accepted non-NOOP beat in ACCUM:
  - acc += sext(`in_psum`) with two's-complement wrap.
  - count += 1, saturating at all-ones.
  - ovf |= signed overflow of the add.
  - mode_err |= (`in_mode` != latched mode).
- Accepted non-NOOP beat with `in_last`:
  - The updated acc, count, mode and flags are loaded into the output registers; `out_valid` = 1.
  - FSM goes to IDLE. A single-beat group is legal.
- Output register is loaded only in that case. It keeps its value while `out_valid && !out_ready`.
- `out_valid` clears on `out_ready` unless it is reloaded in the same cycle. Simultaneous handshake-out and last-beat-in is a reload, so `out_valid` stays 1.
- Reset mid-group: the partial group is discarded and no result is emitted.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_count` = 0, `out_mode` = 0, `out_ovf` = 0, `out_mode_err` = 0.
  - FSM in IDLE; `in_ready` = 1.
- Latency: `out_valid` rises on the edge that accepts the last beat. Results appear 1 cycle after that beat's `in_valid` is sampled.
- Throughput: 1 beat/cycle when `out_ready` is held high, including back-to-back single-beat groups.
- `in_ready` is combinational from `out_valid` and `out_ready` only, never from `in_valid`.

## Configuration
- `PSUM_RELU_EN`
  - Defined: at output-register load, a negative sum is replaced by 0. `out_ovf` and `out_count` are unaffected; the internal acc is not clamped.
  - Undefined: the raw signed sum is output.

## Structure
- The shared package `mfu_pkg` holds:
  - the mode encoding as an enum `mfu_mode_t` (NOOP/M8X8/M4X4/M2X2), reused by the multiply unit's control;
  - the FSM state enum `psum_state_t`;
  - the default `ACC_W`/`CNT_W` constants.
- One sub-module, `psum_out_reg`: the valid/ready output register holding {data, count, mode, ovf, mode_err}.

## Test plan
- Mode 01, beats 100, -30, 7 (last), `out_ready` = 1 → one cycle after the last beat: `out_data` = 77, `out_count` = 3, `out_mode` = 01, both flags 0.
- Single beat -5 with `in_last` in mode 11 → `out_data` = -5, `out_count` = 1. With `PSUM_RELU_EN` defined → `out_data` = 0, `out_count` = 1.
- `out_ready` held 0 after a result → `in_ready` = 0, a second group's beats are not accepted, and the result is stable for 5 cycles. Raising `out_ready` with a last beat pending → `in_ready` = 1 and the new result loads in the same edge.
- ACC_W = 17, beats 32767 ×3 (last) → `out_ovf` = 1 and `out_data` shows the wrapped value.
- Mode 10 beat then mode 01 beat (last) → `out_mode` = 10, `out_mode_err` = 1. A NOOP beat with `in_last` mid-group → no output and the group continues.
- `nrst` pulsed after 2 beats of a group → no output; the next 1-beat group of 9 outputs 9 with count 1.

Source files
------------

// File: rtl/mfu_pkg.sv
// Shared multiply-unit definitions: precision mode encoding, psum FSM states and
// default accumulator/counter widths.
package mfu_pkg;

  typedef enum logic [1:0] {
    NOOP = 2'b00,
    M8X8 = 2'b01,
    M4X4 = 2'b10,
    M2X2 = 2'b11
  } mfu_mode_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } psum_state_t;

  localparam int PSUM_ACC_W = 32;
  localparam int PSUM_CNT_W = 16;

endpackage

// File: rtl/psum_accumulator_if.sv
// Beat input and result output handshakes of the partial-sum accumulator.
// slave = accumulator side, master = upstream source plus downstream sink.
interface psum_accumulator_if
  import mfu_pkg::*;
#(
  parameter int ACC_W = PSUM_ACC_W,
  parameter int CNT_W = PSUM_CNT_W
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [15:0]      in_psum;
  mfu_mode_t               in_mode;
  logic                    in_last;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic [CNT_W-1:0]        out_count;
  mfu_mode_t               out_mode;
  logic                    out_ovf;
  logic                    out_mode_err;

  modport slave (
    input  in_valid, in_psum, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_mode, out_ovf, out_mode_err
  );

  modport master (
    output in_valid, in_psum, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_mode, out_ovf, out_mode_err
  );

endinterface

// File: rtl/psum_out_reg.sv
// Valid/ready result register; holds one finished group until downstream takes it.
module psum_out_reg
  import mfu_pkg::*;
#(
  parameter int ACC_W = PSUM_ACC_W,
  parameter int CNT_W = PSUM_CNT_W
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    load_i,
  input  logic                    ready_i,
  input  logic signed [ACC_W-1:0] data_i,
  input  logic [CNT_W-1:0]        count_i,
  input  mfu_mode_t               mode_i,
  input  logic                    ovf_i,
  input  logic                    merr_i,
  output logic                    valid_o,
  output logic signed [ACC_W-1:0] data_o,
  output logic [CNT_W-1:0]        count_o,
  output mfu_mode_t               mode_o,
  output logic                    ovf_o,
  output logic                    merr_o
);

  logic                    valid_q, valid_d;
  logic signed [ACC_W-1:0] data_q;
  logic [CNT_W-1:0]        count_q;
  mfu_mode_t               mode_q;
  logic                    ovf_q, merr_q;

  // A load in the same cycle as a handshake-out keeps valid high
  assign valid_d = load_i | (valid_q & ~ready_i);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      mode_q  <= NOOP;
      ovf_q   <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        data_q  <= data_i;
        count_q <= count_i;
        mode_q  <= mode_i;
        ovf_q   <= ovf_i;
        merr_q  <= merr_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;
  assign mode_o  = mode_q;
  assign ovf_o   = ovf_q;
  assign merr_o  = merr_q;

endmodule

// File: rtl/psum_accumulator.sv
// Sums signed 16-bit products into per-group dot-product results closed by in_last.
// Build option PSUM_RELU_EN clamps negative results to zero at output load.
module psum_accumulator
  import mfu_pkg::*;
#(
  parameter int ACC_W = PSUM_ACC_W,
  parameter int CNT_W = PSUM_CNT_W
) (
  input logic               clk,
  input logic               nrst,
  psum_accumulator_if.slave bus
);

  psum_state_t             state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  mfu_mode_t               mode_q, mode_d;
  logic                    ovf_q, ovf_d;
  logic                    merr_q, merr_d;

  logic                    beat, load;
  logic signed [ACC_W-1:0] psum_x, sum, res_data;
  logic                    add_ovf;
  logic                    out_valid;

  assign bus.in_ready = !(out_valid && !bus.out_ready);

  // NOOP beats are consumed but never touch state, including their in_last
  assign beat    = bus.in_valid && bus.in_ready && (bus.in_mode != NOOP);
  assign psum_x  = {{(ACC_W-16){bus.in_psum[15]}}, bus.in_psum};
  assign sum     = acc_q + psum_x;
  assign add_ovf = (acc_q[ACC_W-1] == psum_x[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    merr_d  = merr_q;
    load    = 1'b0;
    if (beat) begin
      if (state_q == S_IDLE) begin
        acc_d  = psum_x;
        cnt_d  = CNT_W'(1);
        mode_d = bus.in_mode;
        ovf_d  = 1'b0;
        merr_d = 1'b0;
      end else begin
        acc_d  = sum;
        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        ovf_d  = ovf_q | add_ovf;
        merr_d = merr_q | (bus.in_mode != mode_q);
      end
      if (bus.in_last) begin
        load    = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = S_ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= NOOP;
      ovf_q   <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      merr_q  <= merr_d;
    end
  end

`ifdef PSUM_RELU_EN
  // Clamp only the emitted value; the running sum stays raw
  assign res_data = acc_d[ACC_W-1] ? '0 : acc_d;
`else
  assign res_data = acc_d;
`endif

  psum_out_reg #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_out (
    .clk     (clk),
    .nrst    (nrst),
    .load_i  (load),
    .ready_i (bus.out_ready),
    .data_i  (res_data),
    .count_i (cnt_d),
    .mode_i  (mode_d),
    .ovf_i   (ovf_d),
    .merr_i  (merr_d),
    .valid_o (out_valid),
    .data_o  (bus.out_data),
    .count_o (bus.out_count),
    .mode_o  (bus.out_mode),
    .ovf_o   (bus.out_ovf),
    .merr_o  (bus.out_mode_err)
  );

  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench: directed plan cases plus randomized groups against a sum model.
module tb_psum_accumulator;
  import mfu_pkg::*;

  localparam int ACC_W = 32;
  localparam int CNT_W = 16;
  localparam longint AMAX = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint AMIN = -(longint'(1) << (ACC_W-1));
  localparam longint AMOD = longint'(1) << ACC_W;

  typedef struct {
    longint data;
    int     count;
    int     mode;
    bit     ovf;
    bit     merr;
  } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  psum_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bi ();
  psum_accumulator_if #(.ACC_W(17),    .CNT_W(CNT_W)) b17 ();

  psum_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut   (.clk(clk), .nrst(nrst), .bus(bi.slave));
  psum_accumulator #(.ACC_W(17),    .CNT_W(CNT_W)) dut17 (.clk(clk), .nrst(nrst), .bus(b17.slave));

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  bit   rand_sink = 0;

  // reference model: running group sum in wide integers
  bit     m_open = 0;
  longint m_acc;
  int     m_cnt, m_mode;
  bit     m_ovf, m_merr;

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_beat(input int psum, input int mode, input bit last);
    longint s;
    exp_t e;
    if (mode == 0) return;
    if (!m_open) begin
      m_acc = psum; m_cnt = 1; m_mode = mode; m_ovf = 0; m_merr = 0; m_open = 1;
    end else begin
      s = m_acc + psum;
      if (s > AMAX) begin s -= AMOD; m_ovf = 1; end
      if (s < AMIN) begin s += AMOD; m_ovf = 1; end
      m_acc = s;
      if (m_cnt < 65535) m_cnt++;
      if (mode != m_mode) m_merr = 1;
    end
    if (last) begin
      e.data = m_acc;
`ifdef PSUM_RELU_EN
      if (e.data < 0) e.data = 0;
`endif
      e.count = m_cnt; e.mode = m_mode; e.ovf = m_ovf; e.merr = m_merr;
      sbq.push_back(e);
      m_open = 0;
    end
  endfunction

  task automatic send(input int psum, input int mode, input bit last);
    int tries;
    tries = 0;
    @(negedge clk);
    bi.in_valid = 1'b1;
    bi.in_psum  = 16'(psum);
    bi.in_mode  = mfu_mode_t'(mode[1:0]);
    bi.in_last  = last;
    forever begin
      if (rand_sink) bi.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bi.in_ready) break;
      tries++;
      if (tries > 64) break;
      @(negedge clk);
    end
    if (!bi.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 expected accept within 64 cycles");
    end else begin
      @(posedge clk);
      model_beat(psum, mode, last);
      #1;
    end
    bi.in_valid = 1'b0;
  endtask

  // monitor: compare every handshaken result with the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (nrst) begin
        check("in_ready_rule", bi.in_ready, !(bi.out_valid && !bi.out_ready));
        if (bi.out_valid && bi.out_ready) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected: got result %0d expected none", bi.out_data);
          end else begin
            e = sbq.pop_front();
            check("sb_data",  bi.out_data,   e.data);
            check("sb_count", bi.out_count,  e.count);
            check("sb_mode",  bi.out_mode,   e.mode);
            check("sb_ovf",   bi.out_ovf,    e.ovf);
            check("sb_merr",  bi.out_mode_err, e.merr);
          end
        end
      end
    end
  end

  initial begin
    longint expb;
    int len, md, m, ps, waitc;
    bi.in_valid = 0; bi.in_psum = 0; bi.in_mode = NOOP; bi.in_last = 0; bi.out_ready = 0;
    b17.in_valid = 0; b17.in_psum = 0; b17.in_mode = NOOP; b17.in_last = 0; b17.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bi.out_valid, 0);
    check("rst_out_data",  bi.out_data, 0);
    check("rst_out_count", bi.out_count, 0);
    check("rst_out_mode",  bi.out_mode, 0);
    check("rst_out_ovf",   bi.out_ovf, 0);
    check("rst_out_merr",  bi.out_mode_err, 0);
    check("rst_in_ready",  bi.in_ready, 1);
    @(negedge clk);
    nrst = 1;
    bi.out_ready = 1;

    // 100 - 30 + 7 in 8x8
    send(100, 1, 0); send(-30, 1, 0); send(7, 1, 1);
    check("a_valid", bi.out_valid, 1);
    check("a_data",  bi.out_data, 77);
    check("a_count", bi.out_count, 3);
    check("a_mode",  bi.out_mode, 1);
    check("a_ovf",   bi.out_ovf, 0);
    check("a_merr",  bi.out_mode_err, 0);

    // single-beat group, left pending for the stall case
    send(-5, 3, 1);
`ifdef PSUM_RELU_EN
    expb = 0;
`else
    expb = -5;
`endif
    check("b_data",  bi.out_data, expb);
    check("b_count", bi.out_count, 1);
    @(negedge clk);
    bi.out_ready = 0;
    bi.in_valid = 1; bi.in_psum = 16'(5); bi.in_mode = M8X8; bi.in_last = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", bi.in_ready, 0);
      check("stall_valid",    bi.out_valid, 1);
      check("stall_data",     bi.out_data, expb);
      @(negedge clk);
    end
    bi.out_ready = 1;
    #1;
    check("unstall_in_ready", bi.in_ready, 1);
    @(posedge clk);
    model_beat(5, 1, 1);
    #1;
    bi.in_valid = 0;
    check("reload_valid", bi.out_valid, 1);
    check("reload_data",  bi.out_data, 5);
    check("reload_count", bi.out_count, 1);

    // mode mismatch, NOOP last mid-group ignored
    send(3, 2, 0);
    send(0, 0, 1);
    check("noop_no_out", bi.out_valid, 0);
    send(4, 1, 1);
    check("merr_data", bi.out_data, 7);
    check("merr_count", bi.out_count, 2);
    check("merr_mode", bi.out_mode, 2);
    check("merr_flag", bi.out_mode_err, 1);

    // reset mid-group discards the partial sum
    send(11, 1, 0); send(12, 1, 0);
    check("pre_rst_sb_empty", sbq.size(), 0);
    @(negedge clk);
    nrst = 0;
    m_open = 0;
    @(negedge clk);
    nrst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("post_rst_no_out", bi.out_valid, 0);
    end
    send(9, 1, 1);
    check("rst_next_data",  bi.out_data, 9);
    check("rst_next_count", bi.out_count, 1);

    // 17-bit accumulator overflow: 3 * 32767 wraps
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b17.in_valid = 1; b17.in_psum = 16'sd32767; b17.in_mode = M8X8; b17.in_last = (i == 2);
    end
    @(posedge clk); #1;
    b17.in_valid = 0;
    check("w17_valid", b17.out_valid, 1);
    check("w17_ovf",   b17.out_ovf, 1);
    check("w17_count", b17.out_count, 3);
`ifdef PSUM_RELU_EN
    check("w17_data",  b17.out_data, 0);
`else
    check("w17_data",  b17.out_data, -32771);
`endif

    // randomized groups with random downstream back-pressure
    rand_sink = 1;
    for (int g = 0; g < 250; g++) begin
      len = $urandom_range(1, 6);
      md  = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        m  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : md;
        ps = int'($urandom_range(0, 65535)) - 32768;
        send(ps, m, b == len - 1);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    rand_sink = 0;
    @(negedge clk);
    bi.out_ready = 1;
    waitc = 0;
    while (sbq.size() != 0 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    repeat (2) @(negedge clk);
    check("drain_sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
